march_step_ctrl: RTL and testbench

- Sphere-tracing step controller for one ray.
- Accepts a ray (origin, direction), then repeatedly asks the shared vector FMA unit for pos = t*dir + origin.
- Issues pos to sceneQuery and consumes closestDistance; advances t by the returned distance until hit, escape or step limit.
- Sits directly upstream of sceneQuery (feeds pos/obj_sel, consumes closestDistance/valid_out) and downstream of the ray generator.

---
 rtl/march_step_ctrl.sv | 178 +++++++++++++++++
 tb/tb_march_step_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/march_step_ctrl.sv
// Sphere-tracing step controller for a single ray: alternates position FMA,
// scene query and t-advance FMA until hit, escape or step limit.
module march_step_ctrl #(
  parameter int unsigned MAX_STEPS = 64,
  parameter int unsigned STEP_W    = 7,
  parameter logic [31:0] HIT_EPS   = 32'h3a83126f,
  parameter logic [31:0] MAX_DIST  = 32'h41a00000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_in,
  input  logic [95:0]        ray_origin,
  input  logic [95:0]        ray_dir,
  input  logic               obj_sel,
  output logic               ready_out,
  output logic               done_out,
  output logic               hit,
  output logic [31:0]        t_hit,
  output logic [STEP_W-1:0]  step_count,
  output logic               sq_valid_in,
  output logic [95:0]        sq_pos,
  output logic               sq_obj_sel,
  input  logic [31:0]        sq_distance,
  input  logic               sq_valid_out,
  output logic               fma_valid,
  output logic [95:0]        fma_a,
  output logic [31:0]        fma_s,
  output logic [95:0]        fma_c,
  input  logic [95:0]        fma_result,
  input  logic               fma_done
);

  localparam int unsigned FP_W  = 32;
  localparam int unsigned VEC_W = 3 * FP_W;
  localparam logic [FP_W-1:0] FP_ONE = 32'h3f800000;

  typedef enum logic [3:0] {
    IDLE, POS, POS_WAIT, QUERY, QUERY_WAIT, EVAL, ADV, ADV_WAIT, DONE
  } state_t;

  state_t state, state_next;

  logic [VEC_W-1:0]  origin_q, dir_q;
  logic [FP_W-1:0]   t_q, d_q;
  logic [STEP_W-1:0] steps_q;
  logic              res_hit_q;

  logic              accept;
  logic              d_is_hit;
  logic              step_limit;
  logic              t_escape;
  logic [FP_W-1:0]   t_new;

  logic              fma_valid_d;
  logic [VEC_W-1:0]  fma_a_d, fma_c_d;
  logic [FP_W-1:0]   fma_s_d;

  // Lane x sits in the top word; fp compares are magnitude-only.
  assign accept     = valid_in & ready_out;
  assign t_new      = fma_result[VEC_W-1 -: FP_W];
  assign d_is_hit   = d_q[FP_W-1] | (d_q[FP_W-2:0] < HIT_EPS[FP_W-2:0]);
  assign step_limit = (steps_q == STEP_W'(MAX_STEPS));
  assign t_escape   = (t_new[FP_W-2:0] > MAX_DIST[FP_W-2:0]);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:       if (accept) state_next = POS;
      POS:        state_next = POS_WAIT;
      POS_WAIT:   if (fma_done) state_next = QUERY;
      QUERY:      state_next = QUERY_WAIT;
      QUERY_WAIT: if (sq_valid_out) state_next = EVAL;
      EVAL: begin
        if (d_is_hit || step_limit) state_next = DONE;
        else                        state_next = ADV;
      end
      ADV:        state_next = ADV_WAIT;
      ADV_WAIT: begin
        if (fma_done) state_next = t_escape ? DONE : POS;
      end
      DONE:       state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // FMA request operands, registered so the strobe lines up with POS/ADV
  always_comb begin
    fma_valid_d = 1'b0;
    fma_a_d     = fma_a;
    fma_s_d     = fma_s;
    fma_c_d     = fma_c;
    unique case (state)
      IDLE: if (state_next == POS) begin
        fma_valid_d = 1'b1;
        fma_a_d     = ray_dir;
        fma_s_d     = '0;
        fma_c_d     = ray_origin;
      end
      ADV_WAIT: if (state_next == POS) begin
        fma_valid_d = 1'b1;
        fma_a_d     = dir_q;
        fma_s_d     = t_new;
        fma_c_d     = origin_q;
      end
      EVAL: if (state_next == ADV) begin
        fma_valid_d = 1'b1;
        fma_a_d     = {d_q, (VEC_W-FP_W)'(0)};
        fma_s_d     = FP_ONE;
        fma_c_d     = {t_q, (VEC_W-FP_W)'(0)};
      end
      default: ;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      origin_q    <= '0;
      dir_q       <= '0;
      t_q         <= '0;
      d_q         <= '0;
      steps_q     <= '0;
      res_hit_q   <= 1'b0;
      ready_out   <= 1'b1;
      done_out    <= 1'b0;
      hit         <= 1'b0;
      t_hit       <= '0;
      step_count  <= '0;
      sq_valid_in <= 1'b0;
      sq_pos      <= '0;
      sq_obj_sel  <= 1'b0;
      fma_valid   <= 1'b0;
      fma_a       <= '0;
      fma_s       <= '0;
      fma_c       <= '0;
    end else begin
      ready_out   <= (state_next == IDLE);
      done_out    <= (state == DONE);
      sq_valid_in <= (state_next == QUERY);
      fma_valid   <= fma_valid_d;
      fma_a       <= fma_a_d;
      fma_s       <= fma_s_d;
      fma_c       <= fma_c_d;

      unique case (state)
        IDLE: if (accept) begin
          origin_q   <= ray_origin;
          dir_q      <= ray_dir;
          sq_obj_sel <= obj_sel;
          t_q        <= '0;
          steps_q    <= '0;
        end
        POS_WAIT:   if (fma_done) sq_pos <= fma_result;
        QUERY:      steps_q <= steps_q + STEP_W'(1);
        QUERY_WAIT: if (sq_valid_out) d_q <= sq_distance;
        EVAL:       res_hit_q <= d_is_hit;
        ADV_WAIT: if (fma_done) begin
          t_q       <= t_new;
          res_hit_q <= 1'b0;
        end
        DONE: begin
          hit        <= res_hit_q;
          t_hit      <= t_q;
          step_count <= steps_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_march_step_ctrl.sv
// Directed bench for march_step_ctrl with a 1-cycle behavioural FMA and a
// scripted sceneQuery stub with programmable response delay.
module tb_march_step_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic [95:0] ray_origin = '0;
  logic [95:0] ray_dir = '0;
  logic        obj_sel = 1'b0;
  logic        ready_out, done_out, hit;
  logic [31:0] t_hit;
  logic [6:0]  step_count;
  logic        sq_valid_in;
  logic [95:0] sq_pos;
  logic        sq_obj_sel;
  logic [31:0] sq_distance = '0;
  logic        sq_valid_out = 1'b0;
  logic        fma_valid;
  logic [95:0] fma_a;
  logic [31:0] fma_s;
  logic [95:0] fma_c;
  logic [95:0] fma_result = '0;
  logic        fma_done = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  march_step_ctrl #(.MAX_STEPS(4), .STEP_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
    .ray_origin(ray_origin), .ray_dir(ray_dir), .obj_sel(obj_sel),
    .ready_out(ready_out), .done_out(done_out), .hit(hit), .t_hit(t_hit),
    .step_count(step_count), .sq_valid_in(sq_valid_in), .sq_pos(sq_pos),
    .sq_obj_sel(sq_obj_sel), .sq_distance(sq_distance), .sq_valid_out(sq_valid_out),
    .fma_valid(fma_valid), .fma_a(fma_a), .fma_s(fma_s), .fma_c(fma_c),
    .fma_result(fma_result), .fma_done(fma_done)
  );

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] b;
    if (f[30:23] == 8'd0) return 0.0;
    b = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
    return $bitstoreal(b);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] b;
    logic [31:0] res;
    if (r == 0.0) return 32'd0;
    b   = $realtobits(r);
    res = {b[63], 8'(int'(b[62:52]) - 1023 + 127), b[51:29]};
    if (b[28] && ((|b[27:0]) || b[29])) res = res + 32'd1;
    return res;
  endfunction

  function automatic logic [31:0] fma1(input logic [31:0] a, input logic [31:0] s, input logic [31:0] c);
    return r2f(f2r(a) * f2r(s) + f2r(c));
  endfunction

  // Behavioural FMA, result one cycle after the request
  always @(posedge clk) begin
    fma_done <= fma_valid;
    if (fma_valid)
      fma_result <= {fma1(fma_a[95:64], fma_s, fma_c[95:64]),
                     fma1(fma_a[63:32], fma_s, fma_c[63:32]),
                     fma1(fma_a[31:0],  fma_s, fma_c[31:0])};
  end

  // Scripted sceneQuery stub
  logic [31:0] script [8];
  logic [95:0] pos_log [8];
  logic [31:0] pend_d = '0;
  int q_pulses = 0;
  int sq_base = 0;
  int sq_delay = 0;
  int sq_wait = 0;
  int sq_k;

  always_comb begin
    sq_k = q_pulses - sq_base;
    if (sq_k > 7) sq_k = 7;
    if (sq_k < 0) sq_k = 0;
  end

  always @(posedge clk) begin
    sq_valid_out <= 1'b0;
    if (sq_valid_in) begin
      q_pulses         <= q_pulses + 1;
      pos_log[sq_k]    <= sq_pos;
      pend_d           <= script[sq_k];
      if (sq_delay == 0) begin
        sq_valid_out <= 1'b1;
        sq_distance  <= script[sq_k];
      end else begin
        sq_wait <= sq_delay;
      end
    end else if (sq_wait > 0) begin
      sq_wait <= sq_wait - 1;
      if (sq_wait == 1) begin
        sq_valid_out <= 1'b1;
        sq_distance  <= pend_d;
      end
    end
  end

  task automatic fill_script(input logic [31:0] d0, input logic [31:0] drest);
    script[0] = d0;
    for (int i = 1; i < 8; i++) script[i] = drest;
    sq_base = q_pulses;
  endtask

  task automatic start_ray(input logic [95:0] org, input logic [95:0] dir, input logic sel);
    @(negedge clk);
    ray_origin = org;
    ray_dir    = dir;
    obj_sel    = sel;
    valid_in   = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    obj_sel  = ~sel;
  endtask

  task automatic wait_done(input string tag, output int cyc);
    logic ok;
    ok  = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_out) begin
        cyc = i;
        ok  = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, 96'(ok), 96'(1));
  endtask

  int cyc;
  int base;
  logic seen;

  initial begin
    for (int i = 0; i < 8; i++) begin
      script[i]  = '0;
      pos_log[i] = '0;
    end
    repeat (2) @(negedge clk);
    check("rst_ready", 96'(ready_out), 96'(1));
    check("rst_done", 96'(done_out), 96'(0));
    check("rst_hit_t_steps", {hit, t_hit, step_count}, '0);
    check("rst_strobes", {sq_valid_in, fma_valid}, '0);
    check("rst_sq_pos", sq_pos, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Negative distance on first query: hit at t=0, minimum latency
    fill_script(32'hbf000000, 32'hbf000000);
    start_ray({32'h3f800000, 32'h40000000, 32'h40400000}, {32'h0, 32'h0, 32'h3f800000}, 1'b0);
    wait_done("t1", cyc);
    check("t1_latency", 96'(cyc), 96'(6));
    check("t1_hit", 96'(hit), 96'(1));
    check("t1_steps", 96'(step_count), 96'(1));
    check("t1_t_hit", 96'(t_hit), 96'(0));
    check("t1_pos0", pos_log[0], {32'h3f800000, 32'h40000000, 32'h40400000});
    @(negedge clk);
    check("t1_done_pulse", 96'(done_out), 96'(0));
    check("t1_ready_back", 96'(ready_out), 96'(1));

    // 0.8 then 0.0005 along +z from z=-1
    fill_script(32'h3f4ccccd, 32'h3a03126f);
    start_ray({32'h0, 32'h0, 32'hbf800000}, {32'h0, 32'h0, 32'h3f800000}, 1'b1);
    wait_done("t2", cyc);
    check("t2_hit", 96'(hit), 96'(1));
    check("t2_steps", 96'(step_count), 96'(2));
    check("t2_t_hit", 96'(t_hit), 96'(32'h3f4ccccd));
    check("t2_pos0", pos_log[0], {32'h0, 32'h0, 32'hbf800000});
    // 0.8f - 1.0f is exact in fp32: -0.19999998807907104
    check("t2_pos1", pos_log[1], {32'h0, 32'h0, 32'hbe4ccccc});
    check("t2_obj_sel", 96'(sq_obj_sel), 96'(1));

    // Constant 8.0 steps escape past 20.0 at t=24
    fill_script(32'h41000000, 32'h41000000);
    start_ray('0, {32'h3f800000, 32'h0, 32'h0}, 1'b0);
    @(negedge clk);
    check("t3_hold_hit", 96'(hit), 96'(1));
    check("t3_ready_low", 96'(ready_out), 96'(0));
    wait_done("t3", cyc);
    check("t3_hit", 96'(hit), 96'(0));
    check("t3_steps", 96'(step_count), 96'(3));
    check("t3_t_hit", 96'(t_hit), 96'(32'h41c00000));
    check("t3_obj_sel", 96'(sq_obj_sel), 96'(0));

    // Step limit of 4 with small constant distance
    fill_script(32'h3c23d70a, 32'h3c23d70a);
    base = q_pulses;
    start_ray('0, {32'h0, 32'h3f800000, 32'h0}, 1'b0);
    wait_done("t4", cyc);
    check("t4_hit", 96'(hit), 96'(0));
    check("t4_steps", 96'(step_count), 96'(4));
    check("t4_pulses", 96'(q_pulses - base), 96'(4));

    // Busy drop of valid_in, then reset mid-ray with a late query strobe
    fill_script(32'h41000000, 32'h41000000);
    sq_delay = 20;
    base = q_pulses;
    start_ray('0, {32'h3f800000, 32'h0, 32'h0}, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (q_pulses > base) begin
        seen = 1'b1;
        break;
      end
    end
    check("t5_query_seen", 96'(seen), 96'(1));
    repeat (2) @(negedge clk);
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    check("t5_busy_ready", 96'(ready_out), 96'(0));
    @(negedge clk);
    check("t5_busy_ready2", 96'(ready_out), 96'(0));
    rst_n = 1'b0;
    #1;
    check("t5_rst_ready", 96'(ready_out), 96'(1));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done_out) seen = 1'b1;
    end
    check("t5_no_done", 96'(seen), 96'(0));
    check("t5_ready", 96'(ready_out), 96'(1));
    check("t5_outputs", {hit, t_hit, step_count, sq_valid_in, fma_valid}, '0);
    check("t5_sq_pos", sq_pos, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
